// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Moves one load or store from the EX/MEM stage register to a
//   handshaked memory port. The pipeline is frozen until the memory
//   acknowledges. Lane enables and store data are formatted on the way
//   out. The returned word is lane-selected and extended on the way back.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   MemReadE2M        load request
//   MemWriteE2M       store request (wins when both are high)
//   Funct3E2M         access width/sign code
//   ALUOutE2M         effective byte address
//   StoreDataE2M      store data
//   mem_req/mem_we    memory request / write strobe (registered)
//   mem_addr          word-aligned address (registered)
//   mem_wdata         lane-replicated store data (registered)
//   mem_byteen        byte-lane enables (registered)
//   mem_ack/mem_rdata completion pulse / read word
//   StallM            combinational pipeline freeze
//   LoadDataM         formatted load result, held until the next load
//   LoadValidM        one-cycle pulse when LoadDataM is updated
//   MisalignM         one-cycle misaligned-access pulse
//
// Build option
//   MISALIGN_CHECK_EN: misaligned half/word accesses are rejected with a
//   MisalignM pulse. When it is undefined, MisalignM is 0 and misaligned
//   accesses go to memory using the normal lane selection.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadE2M,
  input  logic        MemWriteE2M,
  input  logic [2:0]  Funct3E2M,
  input  logic [31:0] ALUOutE2M,
  input  logic [31:0] StoreDataE2M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] LoadDataM,
  output logic        LoadValidM,
  output logic        MisalignM
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } stateT;

  stateT       state;
  logic        accessReq;
  logic        startAcc;
  logic [1:0]  offQ;
  logic [2:0]  funct3Q;
  logic [3:0]  byteenD;
  logic [31:0] wdataD;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadFmt;

  assign accessReq = MemReadE2M | MemWriteE2M;

`ifdef MISALIGN_CHECK_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (Funct3E2M[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALUOutE2M[0];
      default: misaligned = |ALUOutE2M[1:0];
    endcase
  end

  assign startAcc = accessReq & ~misaligned;
`else
  assign startAcc  = accessReq;
  assign MisalignM = 1'b0;
`endif

  // Funct3[1:0]: 00 byte, 01 half, 1x word; Funct3[2] selects zero-extension.
  always_comb begin
    byteenD = 4'b1111;
    wdataD  = StoreDataE2M;
    case (Funct3E2M[1:0])
      2'b00: begin
        byteenD = 4'b0001 << ALUOutE2M[1:0];
        wdataD  = {4{StoreDataE2M[7:0]}};
      end
      2'b01: begin
        byteenD = ALUOutE2M[1] ? 4'b1100 : 4'b0011;
        wdataD  = {2{StoreDataE2M[15:0]}};
      end
      default: begin
        byteenD = 4'b1111;
        wdataD  = StoreDataE2M;
      end
    endcase
  end

  // The byte offset and code are kept from request time because mem_addr
  // has lost the low address bits by the time the read data returns.
  always_comb begin
    byteSel = mem_rdata[{offQ, 3'b000} +: 8];
    halfSel = offQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3Q[1:0])
      2'b00:   loadFmt = funct3Q[2] ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadFmt = funct3Q[2] ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadFmt = mem_rdata;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    StallM = startAcc;
      ACCESS:  StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
      LoadDataM  <= '0;
      LoadValidM <= 1'b0;
      offQ       <= '0;
      funct3Q    <= '0;
`ifdef MISALIGN_CHECK_EN
      MisalignM  <= 1'b0;
`endif
    end else begin
      LoadValidM <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      MisalignM  <= (state == IDLE) && accessReq && misaligned;
`endif
      case (state)
        IDLE: begin
          if (startAcc) begin
            state      <= ACCESS;
            mem_req    <= 1'b1;
            mem_we     <= MemWriteE2M;
            mem_addr   <= {ALUOutE2M[31:2], 2'b00};
            mem_wdata  <= wdataD;
            mem_byteen <= byteenD;
            offQ       <= ALUOutE2M[1:0];
            funct3Q    <= Funct3E2M;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              LoadDataM  <= loadFmt;
              LoadValidM <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
